// File: rtl/aes_pkg.sv
// Shared AES decrypt-path types, constants and the InvSubBytes lookup table.
package aes_pkg;

  localparam int unsigned AES_STATE_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } inv_sbytes_state_t;

  // Entry 0x00 sits in the most significant byte.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox_f(input logic [7:0] b);
    int unsigned top;
    top = 32'd2047 - 32'd8 * 32'(b);
    return INV_SBOX_TBL[top -: 8];
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational single-byte AES inverse S-box.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] sub_in,
  output logic [7:0] sub_out
);

  assign sub_out = inv_sbox_f(sub_in);

endmodule

// File: rtl/inv_sbytes_wrap.sv
// AES InvSubBytes stage: substitutes LANES bytes per cycle, byte 0 first, then pulses finished.
module inv_sbytes_wrap
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         inv_sbytes_enable,
  input  logic [127:0] olddata,
  output logic [127:0] newdata,
  output logic         inv_sbytes_finished,
  output logic         inv_sbytes_busy
);

  localparam int unsigned Groups = AES_STATE_BYTES / LANES;
  localparam int unsigned IdxW   = (Groups > 1) ? $clog2(Groups) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Groups - 1);

  inv_sbytes_state_t state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [127:0]      data_q, data_d;
  logic [127:0]      newdata_q, newdata_d;
  logic [LANES-1:0][7:0] lane_in, lane_out;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    inv_sbox u_inv_sbox (
      .sub_in  (lane_in[k]),
      .sub_out (lane_out[k])
    );
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_in[k] = data_q[8 * (32'(idx_q) * LANES + k) +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    newdata_d = newdata_q;
    unique case (state_q)
      IDLE: begin
        if (inv_sbytes_enable) begin
          data_d  = olddata;
          idx_d   = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        for (int k = 0; k < LANES; k++) begin
          newdata_d[8 * (32'(idx_q) * LANES + k) +: 8] = lane_out[k];
        end
        // Hold idx on the last group so it never wraps.
        if (idx_q == LastIdx) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      newdata_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      newdata_q <= newdata_d;
    end
  end

  assign newdata             = newdata_q;
  assign inv_sbytes_finished = (state_q == DONE);
  assign inv_sbytes_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_inv_sbytes_wrap.sv
// Directed bench for inv_sbytes_wrap (LANES=1 and LANES=4 instances).
module tb_inv_sbytes_wrap;

  logic         clk = 1'b0;
  logic         n_rst = 1'b1;
  logic         en1 = 1'b0, en4 = 1'b0;
  logic [127:0] old1 = '0, old4 = '0;
  logic [127:0] new1, new4;
  logic         fin1, fin4, busy1, busy4;

  int n_checks = 0;
  int n_errors = 0;

  // Forward AES S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always #5 clk = ~clk;

  inv_sbytes_wrap #(.LANES(1)) u_dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .inv_sbytes_enable   (en1),
    .olddata             (old1),
    .newdata             (new1),
    .inv_sbytes_finished (fin1),
    .inv_sbytes_busy     (busy1)
  );

  inv_sbytes_wrap #(.LANES(4)) u_dut4 (
    .clk                 (clk),
    .n_rst               (n_rst),
    .inv_sbytes_enable   (en4),
    .olddata             (old4),
    .newdata             (new4),
    .inv_sbytes_finished (fin4),
    .inv_sbytes_busy     (busy4)
  );

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    int unsigned  top;
    for (int i = 0; i < 16; i++) begin
      top = 32'd2047 - 32'd8 * 32'(s[8*i +: 8]);
      r[8*i +: 8] = SBOX_TBL[top -: 8];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One LANES=1 operation: cyc counts cycles after the enable edge (that cycle is 1).
  task automatic run1(input logic [127:0] din, output int cyc, output logic [127:0] snap,
                      output logic [127:0] res);
    old1 = din;
    en1  = 1'b1;
    @(posedge clk); #1;
    en1  = 1'b0;
    old1 = ~din;
    cyc  = 1;
    snap = '0;
    while (!fin1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) snap = new1;
    end
    res = new1;
    @(posedge clk); #1;
    check("fin_one_cycle", 128'(fin1), 128'(0));
    check("busy_after_done", 128'(busy1), 128'(0));
  endtask

  task automatic drain1();
    for (int c = 0; c < 40 && busy1; c++) begin
      @(posedge clk); #1;
    end
    check("drain_idle", 128'(busy1), 128'(0));
  endtask

  initial begin
    int           cyc;
    int           pulses, first, second;
    logic [127:0] snap, res, nd1, nd2, p, pa, pb;

    #1 n_rst = 1'b0;
    #10;
    check("rst_newdata", new1, '0);
    check("rst_finished", 128'(fin1), 128'(0));
    check("rst_busy", 128'(busy1), 128'(0));
    check("rst_newdata4", new4, '0);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;
    check("idle_no_enable", 128'(busy1), 128'(0));

    // All 0x63 -> all 0x00, 17-cycle latency.
    run1({16{8'h63}}, cyc, snap, res);
    check("t1_latency", 128'(cyc), 128'(17));
    check("t1_result", res, '0);
    check("t1_busy_mid", snap, '0);

    run1({16{8'h00}}, cyc, snap, res);
    check("t2a_result", res, {16{8'h52}});
    run1({{15{8'h00}}, 8'hed}, cyc, snap, res);
    check("t2b_result", res, {{15{8'h52}}, 8'h53});

    // Byte 0 first; untouched bytes keep previous result.
    run1({8'h16, {14{8'h63}}, 8'h7c}, cyc, snap, res);
    check("t3_progressive", snap, {{15{8'h52}}, 8'h01});
    check("t3_result", res, {8'hff, {14{8'h00}}, 8'h01});
    check("t3_hold", new1, {8'hff, {14{8'h00}}, 8'h01});

    for (int i = 0; i < 200; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      run1(sub_bytes(p), cyc, snap, res);
      check("roundtrip", res, p);
    end

    // Enable held high: two pulses 18 apart, olddata change mid-op ignored.
    pa = {$urandom, $urandom, $urandom, $urandom};
    pb = {$urandom, $urandom, $urandom, $urandom};
    old1 = sub_bytes(pa);
    en1 = 1'b1;
    pulses = 0; first = -1; second = -1; nd1 = '0; nd2 = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 5) old1 = sub_bytes(pb);
      if (fin1) begin
        pulses++;
        if (pulses == 1) begin
          first = c;
          nd1 = new1;
        end else if (pulses == 2) begin
          second = c;
          nd2 = new1;
        end
      end
    end
    en1 = 1'b0;
    check("held_pulses", 128'(pulses), 128'(2));
    check("held_first", 128'(first), 128'(17));
    check("held_spacing", 128'(second - first), 128'(18));
    check("held_result_a", nd1, pa);
    check("held_result_b", nd2, pb);
    drain1();

    // Asynchronous reset in the middle of SUB.
    old1 = {16{8'h00}};
    en1 = 1'b1;
    @(posedge clk); #1;
    en1 = 1'b0;
    repeat (5) @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("midrst_newdata", new1, '0);
    check("midrst_busy", 128'(busy1), 128'(0));
    check("midrst_fin", 128'(fin1), 128'(0));
    @(negedge clk) n_rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (fin1) pulses++;
    end
    check("midrst_no_pulse", 128'(pulses), 128'(0));
    check("midrst_newdata_kept", new1, '0);

    // LANES=4 instance: finished 5 cycles after the enable edge.
    old4 = {8'h16, {14{8'h63}}, 8'h7c};
    en4 = 1'b1;
    @(posedge clk); #1;
    en4 = 1'b0;
    old4 = '1;
    cyc = 1;
    snap = '0;
    while (!fin4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) snap = new4;
    end
    check("l4_latency", 128'(cyc), 128'(5));
    check("l4_progressive", snap, {{12{8'h00}}, 32'h00000001});
    check("l4_result", new4, {8'hff, {14{8'h00}}, 8'h01});
    @(posedge clk); #1;
    check("l4_fin_one_cycle", 128'(fin4), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
